// File: rtl/mdio_master.sv
// MDIO (Clause 22 / Clause 45) management master: serialises one 32-bit frame
// word behind an optional preamble and captures 16 bits of read data from the PHY.
module mdio_master #(
    parameter int CLK_DIV      = 4,
    parameter int PREAMBLE_LEN = 32,
    parameter int TA_RELEASE   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdio_start,
    input  logic [31:0] t_data,
    input  logic        mdio_in,
    output logic [15:0] rd_data,
    output logic        data_rdy,
    output logic        mdc,
    output logic        mdio_oe,
    output logic        mdio_out,
    output logic        busy,
    output logic        err
);

    localparam int              HALF     = CLK_DIV / 2;
    localparam int              DIV_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
    localparam logic [5:0]      PRE_BITS = 6'(PREAMBLE_LEN);
    localparam logic [5:0]      LAST_BIT = 6'(PREAMBLE_LEN + 31);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        TA,
        DATA_W,
        DATA_R,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [5:0]        bit_q, bit_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [15:0]       shift_q, shift_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              data_rdy_q, data_rdy_d;
    logic              mdc_q, mdc_d;
    logic              mdio_oe_q, mdio_oe_d;
    logic              mdio_out_q, mdio_out_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              is_read;
    logic [5:0]        nxt_bit;
    logic [5:0]        frame_idx;
    state_t            nxt_state;
    logic              nxt_out;
    logic              nxt_oe;

    // Classify the bit that starts at the next mdc falling edge.
    always_comb begin
        is_read   = ((shadow_q[31:30] == 2'b01) && (shadow_q[29:28] == 2'b10)) ||
                    ((shadow_q[31:30] == 2'b00) && shadow_q[29]);
        nxt_bit   = bit_q + 6'd1;
        frame_idx = nxt_bit - PRE_BITS;
        nxt_state = DATA_W;
        if (int'(nxt_bit) < PREAMBLE_LEN) begin
            nxt_state = PRE;
        end else if (frame_idx < 6'd14) begin
            nxt_state = HDR;
        end else if ((frame_idx < 6'd16) && is_read) begin
            nxt_state = TA;
        end else if (is_read) begin
            nxt_state = DATA_R;
        end
        nxt_out = (nxt_state == PRE) ? 1'b1 : shadow_q[5'd31 - frame_idx[4:0]];
        case (nxt_state)
            TA:      nxt_oe = (TA_RELEASE != 0) ? 1'b0 : (frame_idx == 6'd14);
            DATA_R:  nxt_oe = 1'b0;
            default: nxt_oe = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shadow_d   = shadow_q;
        shift_d    = shift_q;
        rd_data_d  = rd_data_q;
        data_rdy_d = 1'b0;
        mdc_d      = mdc_q;
        mdio_oe_d  = mdio_oe_q;
        mdio_out_d = mdio_out_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mdio_start) begin
                    if (t_data[31]) begin
                        err_d = 1'b1;
                    end else begin
                        shadow_d   = t_data;
                        shift_d    = 16'd0;
                        busy_d     = 1'b1;
                        mdc_d      = 1'b0;
                        div_d      = '0;
                        bit_d      = 6'd0;
                        mdio_oe_d  = 1'b1;
                        mdio_out_d = (PREAMBLE_LEN > 0) ? 1'b1 : t_data[31];
                        state_d    = (PREAMBLE_LEN > 0) ? PRE : HDR;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    mdc_d = ~mdc_q;
                    if (!mdc_q) begin
                        if (state_q == DATA_R) begin
                            shift_d = {shift_q[14:0], mdio_in};
                        end
                    end else if (bit_q == LAST_BIT) begin
                        // Last falling edge closes the frame; busy drops here.
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        mdc_d      = 1'b0;
                        mdio_oe_d  = 1'b0;
                        mdio_out_d = 1'b0;
                        if (is_read) begin
                            rd_data_d  = shift_q;
                            data_rdy_d = 1'b1;
                        end
                    end else begin
                        bit_d      = nxt_bit;
                        state_d    = nxt_state;
                        mdio_out_d = nxt_out;
                        mdio_oe_d  = nxt_oe;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= 6'd0;
            shadow_q   <= 32'd0;
            shift_q    <= 16'd0;
            rd_data_q  <= 16'd0;
            data_rdy_q <= 1'b0;
            mdc_q      <= 1'b0;
            mdio_oe_q  <= 1'b0;
            mdio_out_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shadow_q   <= shadow_d;
            shift_q    <= shift_d;
            rd_data_q  <= rd_data_d;
            data_rdy_q <= data_rdy_d;
            mdc_q      <= mdc_d;
            mdio_oe_q  <= mdio_oe_d;
            mdio_out_q <= mdio_out_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign data_rdy = data_rdy_q;
    assign mdc      = mdc_q;
    assign mdio_oe  = mdio_oe_q;
    assign mdio_out = mdio_out_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: default-parameter instance plus a fast
// instance (CLK_DIV=2, no preamble, TA_RELEASE=0), checked against hand-built frames.
module tb_mdio_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        sel;
    logic [31:0] tdata;
    logic        phy_bit;
    logic        start_a, start_b;
    logic [15:0] rd_a, rd_b;
    logic        rdy_a, rdy_b, mdc_a, mdc_b, oe_a, oe_b, out_a, out_b;
    logic        busy_a, busy_b, err_a, err_b;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    mdio_master u_dut_a (
        .clk(clk), .reset(rst_n), .mdio_start(start_a), .t_data(tdata),
        .mdio_in(phy_bit), .rd_data(rd_a), .data_rdy(rdy_a), .mdc(mdc_a),
        .mdio_oe(oe_a), .mdio_out(out_a), .busy(busy_a), .err(err_a)
    );

    mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0), .TA_RELEASE(0)) u_dut_b (
        .clk(clk), .reset(rst_n), .mdio_start(start_b), .t_data(tdata),
        .mdio_in(phy_bit), .rd_data(rd_b), .data_rdy(rdy_b), .mdc(mdc_b),
        .mdio_oe(oe_b), .mdio_out(out_b), .busy(busy_b), .err(err_b)
    );

    logic        mdc_m, oe_m, out_m, busy_m, rdy_m, err_m;
    logic [15:0] rd_m;
    assign mdc_m  = sel ? mdc_b  : mdc_a;
    assign oe_m   = sel ? oe_b   : oe_a;
    assign out_m  = sel ? out_b  : out_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign rdy_m  = sel ? rdy_b  : rdy_a;
    assign err_m  = sel ? err_b  : err_a;
    assign rd_m   = sel ? rd_b   : rd_a;

    int          checks = 0;
    int          errors = 0;
    int          rise_cnt = 0;
    int          pre_len = 32;
    logic [63:0] tx_bits = '0;
    logic [63:0] oe_bits = '0;
    logic [15:0] phy_data = '0;

    // Capture one bit per mdc rise; a new frame (busy rising) clears the record.
    always @(posedge mdc_m or posedge busy_m) begin
        if (mdc_m) begin
            tx_bits  = {tx_bits[62:0], out_m};
            oe_bits  = {oe_bits[62:0], oe_m};
            rise_cnt = rise_cnt + 1;
        end else begin
            tx_bits  = '0;
            oe_bits  = '0;
            rise_cnt = 0;
        end
    end

    // PHY model: presents read data bit j while the master samples rise pre+16+j.
    always_comb begin
        phy_bit = 1'b0;
        if (rise_cnt >= pre_len + 16 && rise_cnt < pre_len + 32)
            phy_bit = phy_data[15 - (rise_cnt - pre_len - 16)];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input string name, input logic [31:0] word, input logic [15:0] phy,
                             input bit rd, input bit ta_rel, input bit dbl, input logic [15:0] prev_rd);
        int          cdiv, total, cyc, rdy, errs, idle_busy;
        logic [63:0] mask, exp_tx, exp_oe, hdr_mask;
        cdiv     = sel ? 2 : 4;
        pre_len  = sel ? 0 : 32;
        total    = pre_len + 32;
        mask     = (total == 64) ? '1 : ((64'd1 << total) - 64'd1);
        exp_tx   = {32'hFFFF_FFFF, word} & mask;
        hdr_mask = rd ? (mask & ~64'h3FFFF) : mask;
        exp_oe   = rd ? (mask & ~(ta_rel ? 64'h3FFFF : 64'h1FFFF)) : mask;
        phy_data = phy;
        @(negedge clk);
        tdata = word;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tdata = ~word;
        cyc = 0; rdy = 0; errs = 0;
        while (busy_m === 1'b1 && cyc < 1000) begin
            if (rdy_m) rdy++;
            if (err_m) errs++;
            start = dbl && (cyc == 20);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_rdy_at_done"}, rdy_m, rd);
        check({name, "_done_idle"}, {mdc_m, oe_m}, 0);
        check({name, "_rd_data"}, rd_m, rd ? phy : prev_rd);
        if (rdy_m) rdy++;
        idle_busy = 0;
        repeat (4 * cdiv) begin
            @(negedge clk);
            if (rdy_m) rdy++;
            if (busy_m) idle_busy++;
        end
        check({name, "_busy_len"}, cyc, total * cdiv);
        check({name, "_rdy_count"}, rdy, rd);
        check({name, "_no_err"}, errs, 0);
        check({name, "_bit_count"}, rise_cnt, total);
        check({name, "_tx_bits"}, tx_bits & hdr_mask, exp_tx & hdr_mask);
        check({name, "_oe_bits"}, oe_bits & mask, exp_oe);
        check({name, "_stays_idle"}, idle_busy, 0);
        $display("frame %s: word=%h busy_cycles=%0d rd_data=%h", name, word, cyc, rd_m);
    endtask

    initial begin
        int w;
        sel = 1'b0; start = 1'b0; tdata = '0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs_a", {busy_a, mdc_a, oe_a, out_a, rdy_a, err_a, rd_a}, 0);
        check("reset_outs_b", {busy_b, mdc_b, oe_b, out_b, rdy_b, err_b, rd_b}, 0);
        rst_n = 1'b1;

        run_frame("c22_wr", 32'h508ABEEF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        run_frame("c22_rd", 32'h61840000, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000);

        @(negedge clk);
        tdata = 32'hC0000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", err_a, 1);
        check("err_busy_mdc", {busy_a, mdc_a}, 0);
        @(negedge clk);
        check("err_clear", {err_a, busy_a, mdc_a}, 0);
        $display("frame err_req: word=c0000000 err observed");

        run_frame("dbl_wr", 32'h5E0F1357, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234);

        @(negedge clk);
        tdata = 32'h5555AAAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (rise_cnt < 40 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("rst_reach_bit40", w < 1000, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_outs", {busy_a, mdc_a, oe_a, out_a, rdy_a, err_a, rd_a}, 0);
        $display("frame mid_reset: reset applied at bit %0d", rise_cnt);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post_rst_wr", 32'h508ABEEF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);

        sel = 1'b1;
        run_frame("c45_rd11", 32'h31840000, 16'hA5C3, 1'b1, 1'b0, 1'b0, 16'h0000);
        run_frame("c45_addr", 32'h0084CAFE, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hA5C3);
        run_frame("c45_rd10", 32'h21840000, 16'h0F0F, 1'b1, 1'b0, 1'b0, 16'hA5C3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per mdc period; even, 2..256.
REQ-002 Parameter PREAMBLE_LEN, default 32, number of preamble '1' bits; 0..32.
REQ-003 Parameter TA_RELEASE, default 1; 1 means mdio_oe drops for the whole TA field of reads, 0 means it drops only for the second TA bit.
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 mdio_start  in  1  one-cycle frame request, sampled on posedge clk.
REQ-007 t_data  in  32  frame word {ST[31:30], OP[29:28], PHYAD/PRTAD[27:23], REGAD/DEVAD[22:18], TA[17:16], DATA/ADDR[15:0]}.
REQ-008 mdio_in  in  1  serial data from the PHY.
REQ-009 rd_data  out  16  last read data.
REQ-010 data_rdy  out  1  one-cycle pulse when rd_data is updated.
REQ-011 mdc  out  1  management clock.
REQ-012 mdio_oe  out  1  1 = master drives MDIO.
REQ-013 mdio_out  out  1  serial data to the PHY.
REQ-014 busy  out  1  frame in progress.
REQ-015 err  out  1  one-cycle pulse on a rejected request.

Function
REQ-016 FSM states: IDLE, PRE, HDR, TA, DATA_W, DATA_R, DONE.
REQ-017 In IDLE, mdio_start=1 with ST=01 (Clause 22) or ST=00 (Clause 45) latches t_data into a shadow register and asserts busy on the next clk.
REQ-018 ST=1x with mdio_start=1 produces an err pulse the next cycle; the FSM stays IDLE and busy stays 0.
REQ-019 mdio_start while busy=1 is ignored, with no err and no effect on the frame in flight.
REQ-020 mdc stays low while idle; while busy it toggles every CLK_DIV/2 clk cycles, starting low.
REQ-021 mdio_out updates only in the clk cycle mdc falls, or the first busy cycle for bit 0; mdio_in is sampled in the clk cycle mdc rises.
REQ-022 PRE drives PREAMBLE_LEN ones with mdio_oe=1; PREAMBLE_LEN=0 skips to HDR.
REQ-023 HDR shifts shadow bits [31:18] out MSB-first (14 bits).
REQ-024 Read ops are C22 OP=10 and C45 OP=11/10; all other ops are write-type, including C45 OP=00 address.
REQ-025 Write-type frames drive TA bits [17:16] then DATA [15:0] with mdio_oe=1 (DATA_W).
REQ-026 Read frames use TA per TA_RELEASE, then hold mdio_oe=0 and shift 16 sampled mdio_in bits into rd_data MSB-first (DATA_R).
REQ-027 After the last bit period, DONE deasserts busy, returns mdc low and mdio_oe=0, and pulses data_rdy for reads only; rd_data updates in that same cycle.
REQ-028 Total busy duration is (PREAMBLE_LEN+32)*CLK_DIV clk cycles.
REQ-029 rd_data holds its value until the next read completes; write frames never alter it.
REQ-030 A bit counter (6 bits) covers preamble and frame without wrap; the divider counter wraps at CLK_DIV/2-1.
REQ-031 t_data changes after acceptance have no effect on the frame in flight.
REQ-032 mdio_start in the DONE cycle is ignored; a new request is accepted one cycle later.

Reset
REQ-033 reset=0 immediately forces IDLE and sets rd_data=0, data_rdy=0, mdc=0, mdio_oe=0, mdio_out=0, busy=0, err=0, and clears all counters and the shadow register, including mid-frame.
REQ-034 After reset deassertion, the first mdio_start is accepted on the next posedge clk.

Verification
REQ-035 Defaults; C22 write t_data=0x508ABEEF -> 32 ones, then 0x508ABEEF MSB-first; mdio_oe=1 throughout; busy for 256 clk; no data_rdy.
REQ-036 C22 read t_data=0x61840000, PHY returns 0x1234 -> mdio_oe falls after 14 header bits; rd_data=0x1234; data_rdy high exactly 1 cycle.
REQ-037 t_data=0xC0000000 with start -> err pulse, busy=0, mdc idle.
REQ-038 CLK_DIV=2, PREAMBLE_LEN=0, C45 read OP=11 -> busy 64 clk; sampled data matches.
REQ-039 reset=0 at bit 40 of a write -> all outputs 0 immediately; a fresh frame after release completes correctly.
REQ-040 Second mdio_start during a frame -> ignored; exactly one frame observed on mdio_out.
